// File: rtl/register_file_pipelined_if.sv
// register_file_pipelined_if: decode-stage bus into the pipelined register file
interface register_file_pipelined_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  enable;
    logic [ADDR_WIDTH-1:0] readRegister1;
    logic [ADDR_WIDTH-1:0] readRegister2;
    logic                  immediate;
    logic [DATA_WIDTH-1:0] ltValue;
    logic                  regWrite;
    logic [ADDR_WIDTH-1:0] writeRegister;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  reserve;
    logic [ADDR_WIDTH-1:0] reserveRegister;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic                  readValid;
    logic                  busy1;
    logic                  busy2;
    logic                  stall;

    modport master (
        output enable, readRegister1, readRegister2, immediate, ltValue,
        output regWrite, writeRegister, writeData, reserve, reserveRegister,
        input  readData1, readData2, readValid, busy1, busy2, stall
    );

    modport slave (
        input  enable, readRegister1, readRegister2, immediate, ltValue,
        input  regWrite, writeRegister, writeData, reserve, reserveRegister,
        output readData1, readData2, readValid, busy1, busy2, stall
    );
endinterface

// File: rtl/register_file_pipelined.sv
// register_file_pipelined: parametrised register file with registered read ports, bypass and busy scoreboard
module register_file_pipelined #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 2**ADDR_WIDTH,
    parameter int ZERO_REG   = 0
) (
    input  logic                    clock,
    input  logic                    resetN,
    register_file_pipelined_if.slave bus
);
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;
    logic [DATA_WIDTH-1:0] r_rd1;
    logic [DATA_WIDTH-1:0] r_rd2;
    logic                  r_valid;

    logic                  w_wr_ok;
    logic                  w_rsv_ok;
    logic                  w_rd1_ok;
    logic                  w_rd2_ok;
    logic                  w_hit1;
    logic                  w_hit2;
    logic [DATA_WIDTH-1:0] w_eff1;
    logic [DATA_WIDTH-1:0] w_eff2;
    logic                  w_busy1;
    logic                  w_busy2;
    logic                  w_stall;
    logic                  w_capture;

    // An address is backed by real storage unless it is out of range or the hardwired zero register
    function automatic logic f_backed(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < NUM_REGS) && !(ZERO_REG != 0 && a == '0);
    endfunction

    // Address qualification, bypass selection and hazard detection
    always_comb begin
        w_wr_ok   = bus.regWrite & f_backed(bus.writeRegister);
        w_rsv_ok  = bus.reserve & f_backed(bus.reserveRegister);
        w_rd1_ok  = f_backed(bus.readRegister1);
        w_rd2_ok  = f_backed(bus.readRegister2);
        w_hit1    = w_wr_ok && bus.writeRegister == bus.readRegister1;
        w_hit2    = w_wr_ok && bus.writeRegister == bus.readRegister2;
        w_eff1    = !w_rd1_ok ? '0 : w_hit1 ? bus.writeData : r_regs[bus.readRegister1];
        w_eff2    = !w_rd2_ok ? '0 : w_hit2 ? bus.writeData : r_regs[bus.readRegister2];
        w_busy1   = w_rd1_ok && r_busy[bus.readRegister1] && !w_hit1;
        w_busy2   = !bus.immediate && w_rd2_ok && r_busy[bus.readRegister2] && !w_hit2;
        w_stall   = w_busy1 | w_busy2;
        w_capture = bus.enable & ~w_stall;
    end

    // Register storage: a qualified write lands on the clock edge
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[bus.writeRegister] <= bus.writeData;
        end
    end

    // Scoreboard: a write retires the producer, a same-cycle reserve re-arms it last so it wins
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_busy <= '0;
        end else begin
            if (w_wr_ok) r_busy[bus.writeRegister] <= 1'b0;
            if (w_rsv_ok) r_busy[bus.reserveRegister] <= 1'b1;
        end
    end

    // Operand latches: capture only when requested and hazard-free, otherwise hold and drop valid
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_rd1 <= w_eff1;
                r_rd2 <= bus.immediate ? bus.ltValue : w_eff2;
            end
        end
    end

    assign bus.readData1 = r_rd1;
    assign bus.readData2 = r_rd2;
    assign bus.readValid = r_valid;
    assign bus.busy1     = w_busy1;
    assign bus.busy2     = w_busy2;
    assign bus.stall     = w_stall;
endmodule

// File: tb/tb_register_file_pipelined.sv
// tb_register_file_pipelined: directed vector table plus async-reset sequence for register_file_pipelined
module tb_register_file_pipelined;
    logic clock = 1'b0;
    logic resetN = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    register_file_pipelined_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    register_file_pipelined #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .NUM_REGS  (7),
        .ZERO_REG  (1)
    ) dut (
        .clock (clock),
        .resetN(resetN),
        .bus   (bus)
    );

    typedef struct {
        logic       en;
        logic [2:0] r1;
        logic [2:0] r2;
        logic       imm;
        logic [7:0] lt;
        logic       rw;
        logic [2:0] wr;
        logic [7:0] wd;
        logic       rsv;
        logic [2:0] rs;
        logic       b1;
        logic       b2;
        logic       st;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       vl;
    } vec_t;

    vec_t v [21];

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [2:0] r1, input logic [2:0] r2, input logic imm,
                         input logic [7:0] lt, input logic rw, input logic [2:0] wr, input logic [7:0] wd,
                         input logic rsv, input logic [2:0] rs);
        bus.enable = en; bus.readRegister1 = r1; bus.readRegister2 = r2; bus.immediate = imm;
        bus.ltValue = lt; bus.regWrite = rw; bus.writeRegister = wr; bus.writeData = wd;
        bus.reserve = rsv; bus.reserveRegister = rs;
    endtask

    initial begin
        v[0]  = '{1,3,5,0,8'h00,0,0,8'h00,0,0, 0,0,0,8'h00,8'h00,1};
        v[1]  = '{0,0,0,0,8'h00,1,2,8'hA5,0,0, 0,0,0,8'h00,8'h00,0};
        v[2]  = '{1,2,2,0,8'h00,0,0,8'h00,0,0, 0,0,0,8'hA5,8'hA5,1};
        v[3]  = '{1,4,2,0,8'h00,1,4,8'h3C,0,0, 0,0,0,8'h3C,8'hA5,1};
        v[4]  = '{1,4,4,0,8'h00,0,0,8'h00,0,0, 0,0,0,8'h3C,8'h3C,1};
        v[5]  = '{0,0,0,0,8'h00,1,1,8'h11,0,0, 0,0,0,8'h3C,8'h3C,0};
        v[6]  = '{0,0,0,0,8'h00,0,0,8'h00,1,5, 0,0,0,8'h3C,8'h3C,0};
        v[7]  = '{1,1,5,1,8'h7F,0,0,8'h00,0,0, 0,0,0,8'h11,8'h7F,1};
        v[8]  = '{1,1,5,0,8'h00,0,0,8'h00,0,0, 0,1,1,8'h11,8'h7F,0};
        v[9]  = '{0,6,0,0,8'h00,0,0,8'h00,1,6, 0,0,0,8'h11,8'h7F,0};
        v[10] = '{1,6,1,0,8'h00,0,0,8'h00,0,0, 1,0,1,8'h11,8'h7F,0};
        v[11] = '{1,6,1,0,8'h00,1,6,8'h42,0,0, 0,0,0,8'h42,8'h11,1};
        v[12] = '{1,6,2,0,8'h00,1,6,8'h99,1,6, 0,0,0,8'h99,8'hA5,1};
        v[13] = '{1,6,6,0,8'h00,0,0,8'h00,0,0, 1,1,1,8'h99,8'hA5,0};
        v[14] = '{1,6,4,0,8'h00,1,6,8'h55,0,0, 0,0,0,8'h55,8'h3C,1};
        v[15] = '{1,0,0,0,8'h00,1,0,8'hFF,0,0, 0,0,0,8'h00,8'h00,1};
        v[16] = '{1,4,2,0,8'h00,0,0,8'h00,1,0, 0,0,0,8'h3C,8'hA5,1};
        v[17] = '{1,0,7,0,8'h00,1,7,8'hEE,0,0, 0,0,0,8'h00,8'h00,1};
        v[18] = '{1,7,4,0,8'h00,0,0,8'h00,0,0, 0,0,0,8'h00,8'h3C,1};
        v[19] = '{0,0,0,0,8'h00,0,0,8'h00,1,7, 0,0,0,8'h00,8'h3C,0};
        v[20] = '{1,7,0,0,8'h00,0,0,8'h00,0,0, 0,0,0,8'h00,8'h00,1};

        drive(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset_rd1", -1, bus.readData1, 8'h00);
        chk("reset_rd2", -1, bus.readData2, 8'h00);
        chk("reset_valid", -1, 8'(bus.readValid), 8'h00);
        @(negedge clock);
        resetN = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clock);
            drive(v[i].en, v[i].r1, v[i].r2, v[i].imm, v[i].lt, v[i].rw, v[i].wr, v[i].wd, v[i].rsv, v[i].rs);
            #1;
            chk("busy1", i, 8'(bus.busy1), 8'(v[i].b1));
            chk("busy2", i, 8'(bus.busy2), 8'(v[i].b2));
            chk("stall", i, 8'(bus.stall), 8'(v[i].st));
            @(posedge clock);
            #1;
            chk("readData1", i, bus.readData1, v[i].d1);
            chk("readData2", i, bus.readData2, v[i].d2);
            chk("readValid", i, 8'(bus.readValid), 8'(v[i].vl));
        end

        @(negedge clock);
        drive(1, 4, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        @(posedge clock);
        #1;
        chk("pre_rst_rd1", 100, bus.readData1, 8'h3C);
        chk("pre_rst_rd2", 100, bus.readData2, 8'h11);
        chk("pre_rst_valid", 100, 8'(bus.readValid), 8'h01);
        @(negedge clock);
        drive(1, 5, 6, 0, 8'h00, 1, 3, 8'h77, 0, 0);
        #1;
        chk("pre_rst_busy1", 101, 8'(bus.busy1), 8'h01);
        resetN = 1'b0;
        #1;
        chk("async_rd1", 102, bus.readData1, 8'h00);
        chk("async_rd2", 102, bus.readData2, 8'h00);
        chk("async_valid", 102, 8'(bus.readValid), 8'h00);
        chk("async_busy1", 102, 8'(bus.busy1), 8'h00);
        @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        drive(1, 5, 3, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        #1;
        chk("post_rst_stall", 103, 8'(bus.stall), 8'h00);
        @(posedge clock);
        #1;
        chk("post_rst_rd1", 103, bus.readData1, 8'h00);
        chk("post_rst_rd2", 103, bus.readData2, 8'h00);
        chk("post_rst_valid", 103, 8'(bus.readValid), 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
